// File: rtl/mem_arbiter_if.sv
// Signals between the memory arbiter, the two caches and the byte-wide RAM/IO port.
// master = arbiter side, slave = caches plus RAM.
interface mem_arbiter_if;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        iIC_en;
  logic [31:0] iIC_pc;
  logic        oIC_done;
  logic [31:0] oIC_dt;
  logic        iDC_en;
  logic        iDC_ls;
  logic [31:0] iDC_pc;
  logic [31:0] iDC_dt;
  logic [2:0]  iDC_len;
  logic        oDC_done;
  logic [31:0] oDC_dt;
  logic [1:0]  oMC_wait;

  modport master (
    input  mem_din, io_buffer_full, iIC_en, iIC_pc, iDC_en, iDC_ls, iDC_pc, iDC_dt, iDC_len,
    output mem_dout, mem_a, mem_wr, oIC_done, oIC_dt, oDC_done, oDC_dt, oMC_wait
  );

  modport slave (
    output mem_din, io_buffer_full, iIC_en, iIC_pc, iDC_en, iDC_ls, iDC_pc, iDC_dt, iDC_len,
    input  mem_dout, mem_a, mem_wr, oIC_done, oIC_dt, oDC_done, oDC_dt, oMC_wait
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin owner of the byte RAM/IO port; reads finish n+1 cycles after grant, writes after n
// (plus one cycle per IO-full stall). A busy requester's new pulses are dropped; rdy low freezes all.
module mem_arbiter #(
  parameter logic [1:0] IO_HI = 2'b11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  mem_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [1:0]  wait_q, wait_d;
  logic        last_q, last_d;          // 0 = icache granted last, 1 = dcache
  logic [31:0] ic_pc_q, ic_pc_d;
  logic [31:0] dc_pc_q, dc_pc_d, dc_dt_q, dc_dt_d;
  logic [2:0]  dc_n_q, dc_n_d;
  logic        dc_ls_q, dc_ls_d;
  logic        own_q, own_d;
  logic [31:0] cur_pc_q, cur_pc_d, cur_dt_q, cur_dt_d;
  logic [2:0]  cur_n_q, cur_n_d, cnt_q, cnt_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        ic_done_q, ic_done_d, dc_done_q, dc_done_d;
  logic [31:0] ic_out_q, ic_out_d, dc_out_q, dc_out_d;

  logic        ic_cap, dc_cap, ic_elig, dc_elig, grant_ic, grant_dc;
  logic [31:0] ic_pc_e, dc_pc_e, dc_dt_e;
  logic [2:0]  dc_n_e, in_n, wr_next;
  logic        dc_ls_e, rd_last, wr_last;
  logic [1:0]  rd_idx;

  function automatic logic io_stall(input logic [1:0] region, input logic full);
    return (region == IO_HI) && full;
  endfunction

  always_comb begin
    case (bus.iDC_len)
      3'd1:    in_n = 3'd1;
      3'd2:    in_n = 3'd2;
      default: in_n = 3'd4;
    endcase
  end

  // A slot captured at this edge competes in the same edge's arbitration.
  assign ic_cap   = bus.iIC_en && !wait_q[0];
  assign dc_cap   = bus.iDC_en && !wait_q[1];
  assign ic_elig  = wait_q[0] || ic_cap;
  assign dc_elig  = wait_q[1] || dc_cap;
  assign grant_dc = dc_elig && (!ic_elig || !last_q);
  assign grant_ic = ic_elig && !grant_dc;

  assign ic_pc_e = ic_cap ? bus.iIC_pc  : ic_pc_q;
  assign dc_pc_e = dc_cap ? bus.iDC_pc  : dc_pc_q;
  assign dc_dt_e = dc_cap ? bus.iDC_dt  : dc_dt_q;
  assign dc_n_e  = dc_cap ? in_n        : dc_n_q;
  assign dc_ls_e = dc_cap ? bus.iDC_ls  : dc_ls_q;

  assign rd_last = (cnt_q == cur_n_q);
  assign rd_idx  = cnt_q[1:0] - 2'd1;
  assign wr_next = cnt_q + {2'b00, mem_wr_q};
  assign wr_last = (wr_next == cur_n_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_ic || (grant_dc && !dc_ls_e)) state_d = RD;
        else if (grant_dc)                      state_d = WR;
      end
      RD:      if (rd_last) state_d = IDLE;
      WR:      if (wr_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wait_d     = wait_q | {dc_cap, ic_cap};
    last_d     = last_q;
    ic_pc_d    = ic_cap ? bus.iIC_pc : ic_pc_q;
    dc_pc_d    = dc_pc_e;
    dc_dt_d    = dc_dt_e;
    dc_n_d     = dc_n_e;
    dc_ls_d    = dc_ls_e;
    own_d      = own_q;
    cur_pc_d   = cur_pc_q;
    cur_dt_d   = cur_dt_q;
    cur_n_d    = cur_n_q;
    cnt_d      = cnt_q;
    rbuf_d     = rbuf_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    ic_done_d  = 1'b0;
    dc_done_d  = 1'b0;
    ic_out_d   = ic_out_q;
    dc_out_d   = dc_out_q;
    case (state_q)
      IDLE: begin
        mem_wr_d = 1'b0;
        if (grant_ic) begin
          last_d   = 1'b0;
          own_d    = 1'b0;
          cur_pc_d = ic_pc_e;
          cur_n_d  = 3'd4;
          cnt_d    = 3'd0;
          rbuf_d   = 32'd0;
          mem_a_d  = ic_pc_e;
        end else if (grant_dc) begin
          last_d   = 1'b1;
          own_d    = 1'b1;
          cur_pc_d = dc_pc_e;
          cur_dt_d = dc_dt_e;
          cur_n_d  = dc_n_e;
          cnt_d    = 3'd0;
          rbuf_d   = 32'd0;
          mem_a_d  = dc_pc_e;
          if (dc_ls_e) begin
            mem_dout_d = dc_dt_e[7:0];
            mem_wr_d   = !io_stall(dc_pc_e[17:16], bus.io_buffer_full);
          end
        end
      end
      RD: begin
        mem_wr_d = 1'b0;
        // RAM data lags its address by one cycle, so this edge lands byte cnt-1.
        if (cnt_q != 3'd0) rbuf_d[{rd_idx, 3'b000} +: 8] = bus.mem_din;
        if (rd_last) begin
          if (own_q) begin
            dc_done_d = 1'b1;
            dc_out_d  = rbuf_d;
            wait_d[1] = 1'b0;
          end else begin
            ic_done_d = 1'b1;
            ic_out_d  = rbuf_d;
            wait_d[0] = 1'b0;
          end
        end else begin
          cnt_d   = cnt_q + 3'd1;
          mem_a_d = cur_pc_q + {29'd0, cnt_d};
        end
      end
      WR: begin
        if (wr_last) begin
          mem_wr_d  = 1'b0;
          dc_done_d = 1'b1;
          dc_out_d  = 32'd0;
          wait_d[1] = 1'b0;
        end else begin
          // A byte only counts as written once a cycle carried it with mem_wr high.
          cnt_d      = wr_next;
          mem_a_d    = cur_pc_q + {29'd0, wr_next};
          mem_dout_d = cur_dt_q[{wr_next[1:0], 3'b000} +: 8];
          mem_wr_d   = !io_stall(mem_a_d[17:16], bus.io_buffer_full);
        end
      end
      default: mem_wr_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q     <= 2'b00;
      last_q     <= 1'b0;
      ic_pc_q    <= 32'd0;
      dc_pc_q    <= 32'd0;
      dc_dt_q    <= 32'd0;
      dc_n_q     <= 3'd0;
      dc_ls_q    <= 1'b0;
      own_q      <= 1'b0;
      cur_pc_q   <= 32'd0;
      cur_dt_q   <= 32'd0;
      cur_n_q    <= 3'd0;
      cnt_q      <= 3'd0;
      rbuf_q     <= 32'd0;
      mem_a_q    <= 32'd0;
      mem_dout_q <= 8'd0;
      mem_wr_q   <= 1'b0;
      ic_done_q  <= 1'b0;
      dc_done_q  <= 1'b0;
      ic_out_q   <= 32'd0;
      dc_out_q   <= 32'd0;
    end else if (rdy) begin
      wait_q     <= wait_d;
      last_q     <= last_d;
      ic_pc_q    <= ic_pc_d;
      dc_pc_q    <= dc_pc_d;
      dc_dt_q    <= dc_dt_d;
      dc_n_q     <= dc_n_d;
      dc_ls_q    <= dc_ls_d;
      own_q      <= own_d;
      cur_pc_q   <= cur_pc_d;
      cur_dt_q   <= cur_dt_d;
      cur_n_q    <= cur_n_d;
      cnt_q      <= cnt_d;
      rbuf_q     <= rbuf_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      ic_done_q  <= ic_done_d;
      dc_done_q  <= dc_done_d;
      ic_out_q   <= ic_out_d;
      dc_out_q   <= dc_out_d;
    end
  end

  assign bus.mem_a    = mem_a_q;
  assign bus.mem_dout = mem_dout_q;
  assign bus.mem_wr   = mem_wr_q;
  assign bus.oIC_done = ic_done_q;
  assign bus.oIC_dt   = ic_out_q;
  assign bus.oDC_done = dc_done_q;
  assign bus.oDC_dt   = dc_out_q;
  assign bus.oMC_wait = wait_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and random checks of mem_arbiter against a byte-array memory model and
// transaction-level expectations (latency, data, arbitration order, write counts).
module tb_mem_arbiter;
  logic clk;
  logic rst;
  logic rdy;
  int   n_cmp    = 0;
  int   n_err    = 0;
  int   wr_count = 0;
  int   ic_dones = 0;
  logic [7:0] ram     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  mem_arbiter_if bus ();

  mem_arbiter #(.IO_HI(2'b11)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] seed_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return seed_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return seed_byte(a);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
    logic [31:0] w;
    w = 32'd0;
    for (int i = 0; i < n; i++) w[8*i +: 8] = ref_rd(a + 32'(i));
    return w;
  endfunction

  function automatic logic [31:0] ram_word(input logic [31:0] a, input int n);
    logic [31:0] w;
    w = 32'd0;
    for (int i = 0; i < n; i++) w[8*i +: 8] = ram_rd(a + 32'(i));
    return w;
  endfunction

  function automatic int nbytes(input logic [2:0] len);
    if (len == 3'd1) return 1;
    if (len == 3'd2) return 2;
    return 4;
  endfunction

  // Synchronous byte RAM sharing the global enable; also tallies writes and icache completions.
  always @(posedge clk) begin
    if (rdy) begin
      if (bus.mem_wr === 1'b1) begin
        ram[bus.mem_a] = bus.mem_dout;
        wr_count++;
      end
      if (bus.oIC_done === 1'b1) ic_dones++;
      bus.mem_din <= ram_rd(bus.mem_a);
    end
  end

  task automatic set_byte(input logic [31:0] a, input logic [7:0] v);
    ram[a]     = v;
    ref_mem[a] = v;
  endtask

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    bus.iIC_en = 1'b0;
    bus.iDC_en = 1'b0;
  endtask

  task automatic req_ic(input logic [31:0] pc);
    bus.iIC_en = 1'b1;
    bus.iIC_pc = pc;
  endtask

  task automatic req_dc(input logic ls, input logic [31:0] pc, input logic [31:0] d, input logic [2:0] len);
    bus.iDC_en  = 1'b1;
    bus.iDC_ls  = ls;
    bus.iDC_pc  = pc;
    bus.iDC_dt  = d;
    bus.iDC_len = len;
  endtask

  // Returns the cycle index (grant cycle = 0) at which done is seen, or -1 on timeout.
  task automatic wait_done(input logic is_ic, input int c0, input int full_edges, output int lat);
    lat = -1;
    for (int c = c0; c < c0 + 60; c++) begin
      if ((is_ic ? bus.oIC_done : bus.oDC_done) === 1'b1) begin
        lat = c;
        break;
      end
      if (c == full_edges - 1) bus.io_buffer_full = 1'b0;
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    logic        is_ic, ls, io;
    logic [2:0]  len;
    int          n, fe, exp_stall, lat, ic0, w0;
    logic [31:0] pc, d, obs;

    rdy = 1'b1;
    bus.iIC_en = 1'b0; bus.iIC_pc = 32'd0;
    bus.iDC_en = 1'b0; bus.iDC_ls = 1'b0; bus.iDC_pc = 32'd0; bus.iDC_dt = 32'd0; bus.iDC_len = 3'd0;
    bus.io_buffer_full = 1'b0;

    do_reset();
    chk("rst_mem_a", bus.mem_a, 32'd0);
    chk("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    chk("rst_mem_dout", 32'(bus.mem_dout), 32'd0);
    chk("rst_wait", 32'(bus.oMC_wait), 32'd0);
    chk("rst_ic_done", 32'(bus.oIC_done), 32'd0);
    chk("rst_dc_done", 32'(bus.oDC_done), 32'd0);
    chk("rst_ic_dt", bus.oIC_dt, 32'd0);
    chk("rst_dc_dt", bus.oDC_dt, 32'd0);
    rst = 1'b0;

    // Uncontended icache fetch with a re-pulse while busy.
    set_byte(32'h100, 8'h11); set_byte(32'h101, 8'h22);
    set_byte(32'h102, 8'h33); set_byte(32'h103, 8'h44);
    ic0 = ic_dones;
    req_ic(32'h100);
    tick();
    chk("ic_a0", bus.mem_a, 32'h100);
    chk("ic_wait_set", 32'(bus.oMC_wait), 32'd1);
    req_ic(32'h200);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk($sformatf("ic_a%0d", k), bus.mem_a, 32'h100 + 32'(k));
      chk($sformatf("ic_wr%0d", k), 32'(bus.mem_wr), 32'd0);
    end
    wait_done(1'b1, 3, 0, lat);
    chk("ic_lat", 32'(lat), 32'd5);
    chk("ic_dt", bus.oIC_dt, 32'h44332211);
    chk("ic_wait_clr", 32'(bus.oMC_wait), 32'd0);
    tick();
    chk("ic_done_pulse", 32'(bus.oIC_done), 32'd0);
    chk("ic_dt_hold", bus.oIC_dt, 32'h44332211);
    repeat (6) tick();
    chk("ic_repulse_ignored", 32'(ic_dones - ic0), 32'd1);

    // rdy low for two edges in the middle of a fetch.
    req_ic(32'h100);
    tick();
    tick();
    chk("rdy_a1", bus.mem_a, 32'h101);
    rdy = 1'b0;
    tick();
    chk("rdy_hold_a", bus.mem_a, 32'h101);
    tick();
    chk("rdy_hold_b", bus.mem_a, 32'h101);
    rdy = 1'b1;
    wait_done(1'b1, 3, 0, lat);
    chk("rdy_lat", 32'(lat), 32'd7);
    chk("rdy_dt", bus.oIC_dt, 32'h44332211);
    tick();

    // IO byte store stalled for three edges.
    w0 = wr_count;
    bus.io_buffer_full = 1'b1;
    req_dc(1'b1, 32'h30000, 32'h000000AB, 3'd1);
    tick();
    chk("io_a0", bus.mem_a, 32'h30000);
    chk("io_stall0", 32'(bus.mem_wr), 32'd0);
    tick();
    chk("io_stall1", 32'(bus.mem_wr), 32'd0);
    tick();
    chk("io_stall2", 32'(bus.mem_wr), 32'd0);
    bus.io_buffer_full = 1'b0;
    tick();
    chk("io_wr", 32'(bus.mem_wr), 32'd1);
    chk("io_wr_a", bus.mem_a, 32'h30000);
    chk("io_wr_d", 32'(bus.mem_dout), 32'hAB);
    tick();
    chk("io_done", 32'(bus.oDC_done), 32'd1);
    chk("io_done_dt", bus.oDC_dt, 32'd0);
    chk("io_done_wr", 32'(bus.mem_wr), 32'd0);
    chk("io_wr_count", 32'(wr_count - w0), 32'd1);
    ref_store(32'h30000, 32'hAB, 1);
    chk("io_ram", 32'(ram_rd(32'h30000)), 32'hAB);
    tick();

    // Contention right after reset: dcache first, then icache, then round robin.
    do_reset();
    rst = 1'b0;
    req_ic(32'h400);
    req_dc(1'b0, 32'h500, 32'd0, 3'd4);
    tick();
    chk("pair1_first", bus.mem_a, 32'h500);
    chk("pair1_wait", 32'(bus.oMC_wait), 32'd3);
    wait_done(1'b0, 0, 0, lat);
    chk("pair1_dc_lat", 32'(lat), 32'd5);
    chk("pair1_dc_dt", bus.oDC_dt, ref_word(32'h500, 4));
    chk("pair1_wait_dc", 32'(bus.oMC_wait), 32'd1);
    tick();
    chk("pair1_ic_next", bus.mem_a, 32'h400);
    wait_done(1'b1, 6, 0, lat);
    chk("pair1_ic_lat", 32'(lat), 32'd11);
    chk("pair1_ic_dt", bus.oIC_dt, ref_word(32'h400, 4));
    tick();
    req_dc(1'b0, 32'h600, 32'd0, 3'd1);
    tick();
    wait_done(1'b0, 0, 0, lat);
    chk("solo_dc_lat", 32'(lat), 32'd2);
    tick();
    req_ic(32'h700);
    req_dc(1'b0, 32'h800, 32'd0, 3'd1);
    tick();
    chk("pair2_first", bus.mem_a, 32'h700);
    wait_done(1'b1, 0, 0, lat);
    chk("pair2_ic_lat", 32'(lat), 32'd5);
    tick();
    chk("pair2_dc_next", bus.mem_a, 32'h800);
    wait_done(1'b0, 6, 0, lat);
    chk("pair2_dc_lat", 32'(lat), 32'd8);
    chk("pair2_dc_dt", bus.oDC_dt, ref_word(32'h800, 1));
    tick();

    // Two-byte load across a 0x2000 boundary.
    set_byte(32'h1FFF, 8'hCD); set_byte(32'h2000, 8'hEF);
    req_dc(1'b0, 32'h1FFF, 32'd0, 3'd2);
    tick();
    chk("h_a0", bus.mem_a, 32'h1FFF);
    tick();
    chk("h_a1", bus.mem_a, 32'h2000);
    wait_done(1'b0, 1, 0, lat);
    chk("h_lat", 32'(lat), 32'd3);
    chk("h_dt", bus.oDC_dt, 32'h0000EFCD);
    tick();

    // Fetch that wraps the 32-bit address space.
    req_ic(32'hFFFFFFFE);
    tick();
    for (int k = 0; k < 4; k++) begin
      pc = 32'hFFFFFFFE + 32'(k);
      chk($sformatf("wrap_a%0d", k), bus.mem_a, pc);
      if (k < 3) tick();
    end
    wait_done(1'b1, 3, 0, lat);
    chk("wrap_lat", 32'(lat), 32'd5);
    chk("wrap_dt", bus.oIC_dt, ref_word(32'hFFFFFFFE, 4));
    tick();

    // Illegal length behaves as a word access.
    req_dc(1'b0, 32'h40, 32'd0, 3'd3);
    tick();
    wait_done(1'b0, 0, 0, lat);
    chk("len3_lat", 32'(lat), 32'd5);
    chk("len3_dt", bus.oDC_dt, ref_word(32'h40, 4));
    tick();

    // Reset in the middle of a fetch: no completion afterwards.
    ic0 = ic_dones;
    req_ic(32'h100);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_wait", 32'(bus.oMC_wait), 32'd0);
    chk("mid_rst_wr", 32'(bus.mem_wr), 32'd0);
    chk("mid_rst_done", 32'(bus.oIC_done), 32'd0);
    rst = 1'b0;
    repeat (8) tick();
    chk("mid_rst_no_done", 32'(ic_dones - ic0), 32'd0);
    req_dc(1'b1, 32'h90, 32'h5A, 3'd1);
    tick();
    chk("mid_rst_idle_wr", 32'(bus.mem_wr), 32'd1);
    chk("mid_rst_idle_a", bus.mem_a, 32'h90);
    wait_done(1'b0, 0, 0, lat);
    chk("mid_rst_st_lat", 32'(lat), 32'd1);
    ref_store(32'h90, 32'h5A, 1);
    tick();

    // Random single transactions against the byte-array reference.
    for (int t = 0; t < 40; t++) begin
      is_ic = ($urandom_range(0, 2) == 0);
      ls    = is_ic ? 1'b0 : 1'($urandom_range(0, 1));
      len   = is_ic ? 3'd4 : 3'($urandom_range(0, 7));
      n     = nbytes(len);
      io    = !is_ic && ($urandom_range(0, 3) == 0);
      d     = $urandom;
      if (io) begin
        pc = 32'h0003_0000 + 32'($urandom_range(0, 255));
        fe = $urandom_range(0, 3);
      end else if ($urandom_range(0, 7) == 0) begin
        pc = 32'hFFFFFFFF - 32'($urandom_range(0, 2));
        fe = 0;
      end else begin
        pc = 32'($urandom_range(0, 4095));
        fe = ($urandom_range(0, 1) == 1) ? 99 : 0;
      end
      exp_stall = (ls && io) ? fe : 0;
      bus.io_buffer_full = (fe != 0);
      if (is_ic) req_ic(pc);
      else       req_dc(ls, pc, d, len);
      tick();
      wait_done(is_ic, 0, fe, lat);
      bus.io_buffer_full = 1'b0;
      chk($sformatf("rnd%0d_lat", t), 32'(lat), ls ? 32'(n + exp_stall) : 32'(n + 1));
      obs = is_ic ? bus.oIC_dt : bus.oDC_dt;
      if (ls) begin
        ref_store(pc, d, n);
        chk($sformatf("rnd%0d_st_dt", t), obs, 32'd0);
        chk($sformatf("rnd%0d_st_ram", t), ram_word(pc, n), ref_word(pc, n));
      end else begin
        chk($sformatf("rnd%0d_ld_dt", t), obs, ref_word(pc, n));
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
